// File: rtl/obstacle_nav_controller.sv
// rtl/obstacle_nav_controller.sv - three-sensor obstacle navigation FSM with PWM motor drive; optional soft start via `define SOFT_START_EN
module obstacle_nav_controller #(
    parameter int SENSOR_W       = 4,
    parameter int PWM_W          = 8,
    parameter int THRESH         = 8,
    parameter int TURN_CYCLES    = 4000,
    parameter int REVERSE_CYCLES = 2000,
    parameter int MAX_TURNS      = 4,
    parameter int DUTY_FWD       = 200,
    parameter int DUTY_TURN      = 160,
    parameter int DUTY_REV       = 120
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               estop,
    input  logic [SENSOR_W-1:0]                sensor_front,
    input  logic [SENSOR_W-1:0]                sensor_left,
    input  logic [SENSOR_W-1:0]                sensor_right,
    output logic                               motorL_pwm,
    output logic                               motorR_pwm,
    output logic                               motorL_dir,
    output logic                               motorR_dir,
    output logic [2:0]                         state_o,
    output logic [$clog2(MAX_TURNS+1)-1:0]     turn_count
);

    localparam int TC_W    = $clog2(MAX_TURNS + 1);
    localparam int MAX_CYC = (TURN_CYCLES > REVERSE_CYCLES) ? TURN_CYCLES : REVERSE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0]    TURN_LAST = TMR_W'(TURN_CYCLES - 1);
    localparam logic [TMR_W-1:0]    REV_LAST  = TMR_W'(REVERSE_CYCLES - 1);
    localparam logic [TC_W-1:0]     TC_SAT    = TC_W'(MAX_TURNS);
    localparam logic [PWM_W-1:0]    D_FWD     = PWM_W'(DUTY_FWD);
    localparam logic [PWM_W-1:0]    D_TURN    = PWM_W'(DUTY_TURN);
    localparam logic [PWM_W-1:0]    D_REV     = PWM_W'(DUTY_REV);
    localparam logic [SENSOR_W-1:0] THR       = SENSOR_W'(THRESH);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FORWARD    = 3'd1,
        TURN_LEFT  = 3'd2,
        TURN_RIGHT = 3'd3,
        REVERSE    = 3'd4,
        STOP       = 3'd5
    } state_t;

    state_t              state;
    logic [TMR_W-1:0]    timer;
    logic [SENSOR_W-1:0] front_q, left_q, right_q;
    logic                obs_f, prefer_left;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [PWM_W-1:0]    tgt_duty_l, tgt_duty_r;
    logic                tgt_dir_l, tgt_dir_r;
    logic [PWM_W-1:0]    app_l_next, app_r_next;

    assign state_o     = state;
    assign obs_f       = front_q > THR;
    assign prefer_left = left_q < right_q;

    // Single register stage on the sensor link; flags derive from these.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            front_q <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            front_q <= sensor_front;
            left_q  <= sensor_left;
            right_q <= sensor_right;
        end
    end

    // Navigation FSM: estop beats enable beats normal flow; timer restarts on every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            turn_count <= '0;
        end else if (estop) begin
            state      <= STOP;
            timer      <= '0;
            turn_count <= '0;
        end else if (state == STOP) begin
            timer      <= '0;
            turn_count <= '0;
            if (!enable) state <= IDLE;
        end else if (!enable) begin
            state      <= IDLE;
            timer      <= '0;
            turn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= FORWARD;
                    timer      <= '0;
                    turn_count <= '0;
                end
                FORWARD: begin
                    timer <= '0;
                    if (obs_f) state <= prefer_left ? TURN_LEFT : TURN_RIGHT;
                end
                TURN_LEFT, TURN_RIGHT: begin
                    if (timer == TURN_LAST) begin
                        timer <= '0;
                        if (!obs_f) begin
                            state      <= FORWARD;
                            turn_count <= '0;
                        end else if (int'(turn_count) + 1 < MAX_TURNS) begin
                            turn_count <= turn_count + TC_W'(1);
                        end else begin
                            state      <= REVERSE;
                            turn_count <= TC_SAT;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                REVERSE: begin
                    if (timer == REV_LAST) begin
                        timer      <= '0;
                        turn_count <= '0;
                        state      <= prefer_left ? TURN_LEFT : TURN_RIGHT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    timer      <= '0;
                    turn_count <= '0;
                end
            endcase
        end
    end

    // Per-state target duty and wheel direction.
    always_comb begin
        tgt_duty_l = '0;
        tgt_duty_r = '0;
        tgt_dir_l  = 1'b0;
        tgt_dir_r  = 1'b0;
        case (state)
            FORWARD: begin
                tgt_duty_l = D_FWD;
                tgt_duty_r = D_FWD;
                tgt_dir_l  = 1'b1;
                tgt_dir_r  = 1'b1;
            end
            TURN_LEFT: begin
                tgt_duty_l = D_TURN;
                tgt_duty_r = D_TURN;
                tgt_dir_r  = 1'b1;
            end
            TURN_RIGHT: begin
                tgt_duty_l = D_TURN;
                tgt_duty_r = D_TURN;
                tgt_dir_l  = 1'b1;
            end
            REVERSE: begin
                tgt_duty_l = D_REV;
                tgt_duty_r = D_REV;
            end
            default: begin
                tgt_duty_l = '0;
                tgt_duty_r = '0;
            end
        endcase
    end

    // Free-running PWM period counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

`ifdef SOFT_START_EN
    logic [PWM_W-1:0] app_l_q, app_r_q, prev_tgt_l_q, prev_tgt_r_q;
    logic             wrap;

    assign wrap = (pwm_cnt == '1);

    // Applied duty: collapse on a duty drop or direction flip, else creep up once per period.
    always_comb begin
        app_l_next = app_l_q;
        app_r_next = app_r_q;
        if (tgt_duty_l < prev_tgt_l_q || tgt_dir_l != motorL_dir)
            app_l_next = '0;
        else if (wrap && app_l_q < tgt_duty_l)
            app_l_next = app_l_q + PWM_W'(1);
        if (tgt_duty_r < prev_tgt_r_q || tgt_dir_r != motorR_dir)
            app_r_next = '0;
        else if (wrap && app_r_q < tgt_duty_r)
            app_r_next = app_r_q + PWM_W'(1);
    end

    // Soft-start history registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            app_l_q      <= '0;
            app_r_q      <= '0;
            prev_tgt_l_q <= '0;
            prev_tgt_r_q <= '0;
        end else begin
            app_l_q      <= app_l_next;
            app_r_q      <= app_r_next;
            prev_tgt_l_q <= tgt_duty_l;
            prev_tgt_r_q <= tgt_duty_r;
        end
    end
`else
    assign app_l_next = tgt_duty_l;
    assign app_r_next = tgt_duty_r;
`endif

    // Motor outputs: pwm and dir share one edge so a direction flip never sees a stale pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            motorL_pwm <= 1'b0;
            motorR_pwm <= 1'b0;
            motorL_dir <= 1'b0;
            motorR_dir <= 1'b0;
        end else begin
            motorL_pwm <= (pwm_cnt < app_l_next);
            motorR_pwm <= (pwm_cnt < app_r_next);
            motorL_dir <= tgt_dir_l;
            motorR_dir <= tgt_dir_r;
        end
    end

endmodule
